// File: rtl/hmcs_disp_pkg.sv
// hmcs_disp_pkg: shared display types and helpers for the VFD capture path
package hmcs_disp_pkg;
  localparam int NGRID = 16;
  localparam int NSEG = 16;
  typedef logic [NGRID-1:0] grid_t;
  typedef logic [NSEG-1:0] seg_t;
  typedef logic [3:0] pers_t;
  function automatic logic [3:0] lowest_set(grid_t g);
    logic [3:0] r;
    r = '0;
    for (int i = NGRID - 1; i >= 0; i--) if (g[i]) r = 4'(i);
    return r;
  endfunction
endpackage

// File: rtl/hmcs_persist_row.sv
// hmcs_persist_row: one grid row of the frame with phosphor-style persistence
module hmcs_persist_row
  import hmcs_disp_pkg::*;
#(
  parameter logic [3:0] PERSIST = 4'd7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        decay,
  input  logic [15:0] load_data,
  output logic [15:0] data,
  output logic        lit
);
  seg_t frame_q, frame_d;
  pers_t pers_q, pers_d;
  // a capture overrides a simultaneous decay; decaying to zero blanks the row
  always_comb begin
    pers_d = load ? PERSIST : (decay && pers_q != '0) ? pers_q - 4'd1 : pers_q;
    frame_d = load ? load_data : (pers_d == '0) ? '0 : frame_q;
  end
  // row state register
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q <= '0;
      pers_q <= '0;
    end else begin
      frame_q <= frame_d;
      pers_q <= pers_d;
    end
  end
  assign data = frame_q;
  assign lit = pers_q != '0;
endmodule

// File: rtl/hmcs_vfd_capture.sv
// hmcs_vfd_capture: settles multiplexed grid/segment drive into a persistent 16x16 frame
module hmcs_vfd_capture
  import hmcs_disp_pkg::*;
#(
  parameter int SETTLE = 4,
  parameter int PERSIST = 7,
  parameter int DECAY_DIV = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic [15:0] i_grid,
  input  logic [15:0] i_seg,
  input  logic [3:0]  rd_addr,
  output logic [15:0] rd_data,
  output logic        rd_lit,
  output logic        o_scan_done
);
  localparam int DW = $clog2(DECAY_DIV);
  localparam logic [DW-1:0] DMAX = DW'(DECAY_DIV - 1);
  logic [31:0] smp_q, smp_d;
  logic [3:0] stable_cnt_q, stable_cnt_d, last_lo_q, last_lo_d, lo;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic cap_done_q, cap_done_d, scan_pend_q, scan_pend_d, scan_q, scan_d;
  logic [15:0] rd_data_q, rd_data_d;
  logic rd_lit_q, rd_lit_d;
  logic same, capture, wrap;
  seg_t row_data [NGRID];
  logic [NGRID-1:0] row_lit;
  assign same = {i_grid, i_seg} == smp_q;
  assign capture = ce && same && (stable_cnt_q + 4'd1 == 4'(SETTLE)) && !cap_done_q && i_grid != '0;
  assign wrap = ce && div_cnt_q == DMAX;
  assign lo = lowest_set(i_grid);
  // sampler, settle counter, decay divider, scan-wrap detect and read mux
  always_comb begin
    smp_d = ce ? {i_grid, i_seg} : smp_q;
    stable_cnt_d = !ce ? stable_cnt_q : !same ? 4'd0 : (stable_cnt_q == 4'hf) ? 4'hf : stable_cnt_q + 4'd1;
    cap_done_d = capture || (cap_done_q && !(ce && !same));
    div_cnt_d = !ce ? div_cnt_q : wrap ? '0 : div_cnt_q + DW'(1);
    last_lo_d = capture ? lo : last_lo_q;
    scan_pend_d = capture && lo <= last_lo_q;
    scan_d = scan_pend_q;
    rd_data_d = row_data[rd_addr];
    rd_lit_d = row_lit[rd_addr];
  end
  // control and read-port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      smp_q <= '0;
      stable_cnt_q <= '0;
      cap_done_q <= 1'b0;
      div_cnt_q <= '0;
      last_lo_q <= 4'hf;
      scan_pend_q <= 1'b0;
      scan_q <= 1'b0;
      rd_data_q <= '0;
      rd_lit_q <= 1'b0;
    end else begin
      smp_q <= smp_d;
      stable_cnt_q <= stable_cnt_d;
      cap_done_q <= cap_done_d;
      div_cnt_q <= div_cnt_d;
      last_lo_q <= last_lo_d;
      scan_pend_q <= scan_pend_d;
      scan_q <= scan_d;
      rd_data_q <= rd_data_d;
      rd_lit_q <= rd_lit_d;
    end
  end
  for (genvar g = 0; g < NGRID; g++) begin : g_row
    hmcs_persist_row #(.PERSIST(pers_t'(PERSIST))) u_row (
      .clk(clk),
      .reset(reset),
      .load(capture && i_grid[g]),
      .decay(wrap),
      .load_data(i_seg),
      .data(row_data[g]),
      .lit(row_lit[g])
    );
  end
  assign rd_data = rd_data_q;
  assign rd_lit = rd_lit_q;
  assign o_scan_done = scan_q;
endmodule

// File: tb/tb_hmcs_vfd_capture.sv
// tb_hmcs_vfd_capture: directed checks of settle, glitch, decay, collision, scan wrap and reset
module tb_hmcs_vfd_capture;
  logic clk = 0, reset = 0, ce = 0;
  logic [15:0] i_grid = '0, i_seg = '0;
  logic [3:0] rd_addr = '0;
  logic [15:0] rd_data;
  logic rd_lit, o_scan_done;
  int n_cmp = 0, n_bad = 0;

  hmcs_vfd_capture #(.SETTLE(4), .PERSIST(2), .DECAY_DIV(4)) dut (
    .clk(clk), .reset(reset), .ce(ce), .i_grid(i_grid), .i_seg(i_seg),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_lit(rd_lit), .o_scan_done(o_scan_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input logic [15:0] g, input logic [15:0] s);
    @(negedge clk);
    i_grid = g;
    i_seg = s;
    ce = 1;
    @(posedge clk);
    #1;
    ce = 0;
  endtask

  task automatic hold(input logic [15:0] g, input logic [15:0] s, input int n);
    for (int i = 0; i < n; i++) tick(g, s);
  endtask

  task automatic rd(input logic [3:0] a);
    @(negedge clk);
    rd_addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1;
    ce = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic test_reset;
    do_reset;
    n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL reset_rd_data got %h want 0000", rd_data); end
    n_cmp++; if (rd_lit !== 1'b0) begin n_bad++; $display("FAIL reset_rd_lit got %b want 0", rd_lit); end
    n_cmp++; if (o_scan_done !== 1'b0) begin n_bad++; $display("FAIL reset_scan got %b want 0", o_scan_done); end
  endtask

  task automatic test_settle;
    do_reset;
    hold(16'h0001, 16'h00A5, 4);
    rd(0);
    n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL settle_early_data got %h want 0000", rd_data); end
    n_cmp++; if (rd_lit !== 1'b0) begin n_bad++; $display("FAIL settle_early_lit got %b want 0", rd_lit); end
    tick(16'h0001, 16'h00A5);
    rd(0);
    n_cmp++; if (rd_data !== 16'h00A5) begin n_bad++; $display("FAIL settle_data got %h want 00a5", rd_data); end
    n_cmp++; if (rd_lit !== 1'b1) begin n_bad++; $display("FAIL settle_lit got %b want 1", rd_lit); end
  endtask

  task automatic test_glitch;
    do_reset;
    for (int k = 0; k < 4; k++) hold(16'h0002, 16'(k + 1), 2);
    rd(1);
    n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL glitch_reject got %h want 0000", rd_data); end
    hold(16'h0002, 16'h1234, 4);
    rd(1);
    n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL glitch_early got %h want 0000", rd_data); end
    tick(16'h0002, 16'h1234);
    rd(1);
    n_cmp++; if (rd_data !== 16'h1234) begin n_bad++; $display("FAIL glitch_data got %h want 1234", rd_data); end
    n_cmp++; if (rd_lit !== 1'b1) begin n_bad++; $display("FAIL glitch_lit got %b want 1", rd_lit); end
  endtask

  task automatic test_decay;
    do_reset;
    hold(16'h0008, 16'h0F0F, 5);
    hold(16'h0000, 16'h0000, 3);
    rd(3);
    n_cmp++; if (rd_data !== 16'h0F0F || rd_lit !== 1'b1) begin n_bad++; $display("FAIL decay_wrap1 got %h/%b want 0f0f/1", rd_data, rd_lit); end
    hold(16'h0000, 16'h0000, 3);
    rd(3);
    n_cmp++; if (rd_data !== 16'h0F0F || rd_lit !== 1'b1) begin n_bad++; $display("FAIL decay_pre_wrap2 got %h/%b want 0f0f/1", rd_data, rd_lit); end
    tick(16'h0000, 16'h0000);
    rd(3);
    n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL decay_data got %h want 0000", rd_data); end
    n_cmp++; if (rd_lit !== 1'b0) begin n_bad++; $display("FAIL decay_lit got %b want 0", rd_lit); end
    tick(16'h0000, 16'h0000);
  endtask

  task automatic test_collision;
    do_reset;
    hold(16'h0020, 16'h1111, 7);
    rd(5);
    n_cmp++; if (rd_data !== 16'h1111 || rd_lit !== 1'b1) begin n_bad++; $display("FAIL coll_old got %h/%b want 1111/1", rd_data, rd_lit); end
    hold(16'h0020, 16'h2222, 5);
    rd(5);
    n_cmp++; if (rd_data !== 16'h2222 || rd_lit !== 1'b1) begin n_bad++; $display("FAIL coll_new got %h/%b want 2222/1", rd_data, rd_lit); end
    hold(16'h0000, 16'h0000, 4);
    rd(5);
    n_cmp++; if (rd_data !== 16'h2222 || rd_lit !== 1'b1) begin n_bad++; $display("FAIL coll_reload got %h/%b want 2222/1", rd_data, rd_lit); end
    hold(16'h0000, 16'h0000, 4);
    rd(5);
    n_cmp++; if (rd_data !== 16'h0 || rd_lit !== 1'b0) begin n_bad++; $display("FAIL coll_expire got %h/%b want 0000/0", rd_data, rd_lit); end
  endtask

  task automatic test_scan;
    int gs [5] = '{15, 0, 1, 2, 0};
    logic exp_p [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset;
    for (int k = 0; k < 5; k++) begin
      hold(16'h1 << gs[k], 16'(16'h100 + k), 5);
      n_cmp++; if (o_scan_done !== 1'b0) begin n_bad++; $display("FAIL scan_early[%0d] got %b want 0", k, o_scan_done); end
      @(posedge clk); #1;
      n_cmp++; if (o_scan_done !== exp_p[k]) begin n_bad++; $display("FAIL scan_pulse[%0d] got %b want %b", k, o_scan_done, exp_p[k]); end
      @(posedge clk); #1;
      n_cmp++; if (o_scan_done !== 1'b0) begin n_bad++; $display("FAIL scan_late[%0d] got %b want 0", k, o_scan_done); end
    end
  endtask

  task automatic test_reset_mid;
    do_reset;
    hold(16'h0001, 16'h00A5, 5);
    hold(16'h0010, 16'h5555, 3);
    rd(0);
    n_cmp++; if (rd_data !== 16'h00A5 || rd_lit !== 1'b1) begin n_bad++; $display("FAIL mid_pre got %h/%b want 00a5/1", rd_data, rd_lit); end
    do_reset;
    n_cmp++; if (rd_data !== 16'h0 || rd_lit !== 1'b0) begin n_bad++; $display("FAIL mid_reset got %h/%b want 0000/0", rd_data, rd_lit); end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      n_cmp++; if (rd_data !== 16'h0 || rd_lit !== 1'b0) begin n_bad++; $display("FAIL mid_row[%0d] got %h/%b want 0000/0", a, rd_data, rd_lit); end
    end
    hold(16'h0010, 16'h5555, 4);
    rd(4);
    n_cmp++; if (rd_data !== 16'h0) begin n_bad++; $display("FAIL mid_resettle_early got %h want 0000", rd_data); end
    tick(16'h0010, 16'h5555);
    rd(4);
    n_cmp++; if (rd_data !== 16'h5555 || rd_lit !== 1'b1) begin n_bad++; $display("FAIL mid_resettle got %h/%b want 5555/1", rd_data, rd_lit); end
  endtask

  initial begin
    test_reset;
    test_settle;
    test_glitch;
    test_decay;
    test_collision;
    test_scan;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
